// File: rtl/grant_burst_ctrl_pkg.sv
// Shared definitions for the arbiter and its downstream burst controller:
// controller state encodings and default sizing constants.
package arb_pkg;

    localparam int ARB_N     = 4;
    localparam int ARB_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/grant_burst_ctrl_if.sv
// Grant/burst handshake bundle between the requester side and the burst controller.
interface grant_burst_ctrl_if #(
    parameter int N     = 4,
    parameter int CNT_W = 4
);
    logic [N-1:0]     req;
    logic [N-1:0]     grant_in;
    logic [CNT_W-1:0] burst_len;
    logic             beat_valid;
    logic [N-1:0]     owner;
    logic             busy;
    logic             beat_ready;
    logic [CNT_W-1:0] beats_left;
    logic             done;
    logic             aborted;
    logic             grant_err;

    modport master (
        output req, grant_in, burst_len, beat_valid,
        input  owner, busy, beat_ready, beats_left, done, aborted, grant_err
    );

    modport slave (
        input  req, grant_in, burst_len, beat_valid,
        output owner, busy, beat_ready, beats_left, done, aborted, grant_err
    );
endinterface

// File: rtl/grant_burst_ctrl_onehot_check.sv
// Classifies an N-bit vector as exactly one-hot or multi-hot (zero is neither).
module onehot_check #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_vec,
    output logic         o_is_onehot,
    output logic         o_is_multi
);
    logic w_nonzero;
    logic w_single;

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign w_nonzero   = |i_vec;
    assign w_single    = ((i_vec & (i_vec - N'(1))) == '0);
    assign o_is_onehot = w_nonzero && w_single;
    assign o_is_multi  = w_nonzero && !w_single;
endmodule

// File: rtl/grant_burst_ctrl.sv
// Locks ownership to the arbiter's one-hot winner for a programmable burst,
// counts accepted beats and reports completion/abort as single-cycle pulses.
module grant_burst_ctrl
    import arb_pkg::*;
#(
    parameter int N     = ARB_N,
    parameter int CNT_W = ARB_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    grant_burst_ctrl_if.slave bus
);
    state_t           r_state, w_state_nxt;
    logic [N-1:0]     r_owner, w_owner_nxt;
    logic [CNT_W-1:0] r_beats_left, w_beats_nxt;
    logic             r_busy, r_done, r_aborted, r_grant_err;
    logic             w_done_nxt, w_aborted_nxt, w_grant_err_nxt;
    logic             w_is_onehot, w_is_multi;
    logic             w_owner_req;

    onehot_check #(.N(N)) u_onehot (
        .i_vec       (bus.grant_in),
        .o_is_onehot (w_is_onehot),
        .o_is_multi  (w_is_multi)
    );

    assign w_owner_req = |(bus.req & r_owner);

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_beats_nxt     = r_beats_left;
        w_done_nxt      = 1'b0;
        w_aborted_nxt   = 1'b0;
        w_grant_err_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_is_onehot) begin
                    w_state_nxt = ST_XFER;
                    w_owner_nxt = bus.grant_in;
                    w_beats_nxt = (bus.burst_len == '0) ? CNT_W'(1) : bus.burst_len;
                end else if (w_is_multi) begin
                    w_grant_err_nxt = 1'b1;
                end
            end
            ST_XFER: begin
                // A dropped request wins over a simultaneous beat.
                if (!w_owner_req) begin
                    w_state_nxt   = ST_RELEASE;
                    w_aborted_nxt = 1'b1;
                end else if (bus.beat_valid) begin
                    w_beats_nxt = r_beats_left - CNT_W'(1);
                    if (r_beats_left == CNT_W'(1)) begin
                        w_state_nxt = ST_RELEASE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_owner_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_beats_left <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_grant_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_beats_left <= w_beats_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_done       <= w_done_nxt;
            r_aborted    <= w_aborted_nxt;
            r_grant_err  <= w_grant_err_nxt;
        end
    end

    assign bus.owner      = r_owner;
    assign bus.busy       = r_busy;
    assign bus.beat_ready = (r_state == ST_XFER);
    assign bus.beats_left = r_beats_left;
    assign bus.done       = r_done;
    assign bus.aborted    = r_aborted;
    assign bus.grant_err  = r_grant_err;
endmodule

// File: tb/tb_grant_burst_ctrl.sv
// Directed bench for grant_burst_ctrl: reset, bursts, abort, lock stability,
// edge inputs and asynchronous reset, with hand-computed expectations.
module tb_grant_burst_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    grant_burst_ctrl_if #(.N(4), .CNT_W(4)) bus ();

    grant_burst_ctrl #(.N(4), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks every registered output plus beat_ready in one call.
    task automatic chk_all(input string tag, input logic [3:0] own, input logic bsy,
                           input logic rdy, input logic [3:0] bl, input logic dn,
                           input logic ab, input logic ge);
        chk({tag, ".owner"},      32'(bus.owner),      32'(own));
        chk({tag, ".busy"},       32'(bus.busy),       32'(bsy));
        chk({tag, ".beat_ready"}, 32'(bus.beat_ready), 32'(rdy));
        chk({tag, ".beats_left"}, 32'(bus.beats_left), 32'(bl));
        chk({tag, ".done"},       32'(bus.done),       32'(dn));
        chk({tag, ".aborted"},    32'(bus.aborted),    32'(ab));
        chk({tag, ".grant_err"},  32'(bus.grant_err),  32'(ge));
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        bus.req        = 4'b0000;
        bus.grant_in   = 4'b0000;
        bus.burst_len  = 4'd0;
        bus.beat_valid = 1'b0;
        step();
        step();
        chk_all("reset", 4'b0000, 0, 0, 4'd0, 0, 0, 0);
        reset = 1'b0;

        // Idle with no grant
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("idle", 4'b0000, 0, 0, 4'd0, 0, 0, 0);
        end

        // Normal 3-beat burst
        bus.req = 4'b0100; bus.grant_in = 4'b0100; bus.burst_len = 4'd3; bus.beat_valid = 1'b1;
        step();
        chk_all("nb_lock", 4'b0100, 1, 1, 4'd3, 0, 0, 0);
        bus.grant_in = 4'b0000;
        step();
        chk_all("nb_b1", 4'b0100, 1, 1, 4'd2, 0, 0, 0);
        step();
        chk_all("nb_b2", 4'b0100, 1, 1, 4'd1, 0, 0, 0);
        step();
        chk_all("nb_b3", 4'b0100, 1, 0, 4'd0, 1, 0, 0);
        step();
        chk_all("nb_idle", 4'b0000, 0, 0, 4'd0, 0, 0, 0);

        // Abort after two beats of a 5-beat burst
        bus.req = 4'b0001; bus.grant_in = 4'b0001; bus.burst_len = 4'd5; bus.beat_valid = 1'b1;
        step();
        chk_all("ab_lock", 4'b0001, 1, 1, 4'd5, 0, 0, 0);
        bus.grant_in = 4'b0000;
        step();
        chk_all("ab_b1", 4'b0001, 1, 1, 4'd4, 0, 0, 0);
        step();
        chk_all("ab_b2", 4'b0001, 1, 1, 4'd3, 0, 0, 0);
        bus.req = 4'b0000;
        step();
        chk_all("ab_pulse", 4'b0001, 1, 0, 4'd3, 0, 1, 0);
        step();
        chk_all("ab_idle", 4'b0000, 0, 0, 4'd3, 0, 0, 0);

        // Higher-priority grant mid-burst must not move ownership
        bus.req = 4'b0100; bus.grant_in = 4'b0100; bus.burst_len = 4'd4; bus.beat_valid = 1'b0;
        step();
        chk_all("ls_lock", 4'b0100, 1, 1, 4'd4, 0, 0, 0);
        bus.grant_in = 4'b0001; bus.req = 4'b0101;
        step();
        chk_all("ls_stall", 4'b0100, 1, 1, 4'd4, 0, 0, 0);
        bus.beat_valid = 1'b1;
        step();
        chk_all("ls_b1", 4'b0100, 1, 1, 4'd3, 0, 0, 0);
        step();
        chk_all("ls_b2", 4'b0100, 1, 1, 4'd2, 0, 0, 0);
        step();
        chk_all("ls_b3", 4'b0100, 1, 1, 4'd1, 0, 0, 0);
        step();
        chk_all("ls_b4", 4'b0100, 1, 0, 4'd0, 1, 0, 0);
        bus.grant_in = 4'b0000; bus.req = 4'b0000; bus.beat_valid = 1'b0;
        step();
        chk_all("ls_idle", 4'b0000, 0, 0, 4'd0, 0, 0, 0);

        // burst_len of zero behaves as a single beat
        bus.req = 4'b0010; bus.grant_in = 4'b0010; bus.burst_len = 4'd0; bus.beat_valid = 1'b1;
        step();
        chk_all("z_lock", 4'b0010, 1, 1, 4'd1, 0, 0, 0);
        bus.grant_in = 4'b0000;
        step();
        chk_all("z_done", 4'b0010, 1, 0, 4'd0, 1, 0, 0);
        step();
        chk_all("z_idle", 4'b0000, 0, 0, 4'd0, 0, 0, 0);

        // Multi-hot grant in IDLE
        bus.req = 4'b0101; bus.grant_in = 4'b0101; bus.beat_valid = 1'b0;
        step();
        chk_all("ge_pulse", 4'b0000, 0, 0, 4'd0, 0, 0, 1);
        bus.grant_in = 4'b0000; bus.req = 4'b0000;
        step();
        chk_all("ge_clear", 4'b0000, 0, 0, 4'd0, 0, 0, 0);

        // Asynchronous reset between edges mid-XFER
        bus.req = 4'b1000; bus.grant_in = 4'b1000; bus.burst_len = 4'd3; bus.beat_valid = 1'b1;
        step();
        chk_all("ar_lock", 4'b1000, 1, 1, 4'd3, 0, 0, 0);
        bus.grant_in = 4'b0000;
        step();
        chk_all("ar_b1", 4'b1000, 1, 1, 4'd2, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk_all("ar_async", 4'b0000, 0, 0, 4'd0, 0, 0, 0);
        #1 reset = 1'b0;
        bus.grant_in = 4'b1000; bus.burst_len = 4'd2;
        step();
        chk_all("ar_relock", 4'b1000, 1, 1, 4'd2, 0, 0, 0);
        bus.grant_in = 4'b0000;
        step();
        chk_all("ar_b1b", 4'b1000, 1, 1, 4'd1, 0, 0, 0);
        step();
        chk_all("ar_done", 4'b1000, 1, 0, 4'd0, 1, 0, 0);
        bus.req = 4'b0000; bus.beat_valid = 1'b0;
        step();
        chk_all("ar_idle", 4'b0000, 0, 0, 4'd0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/grant_burst_ctrl.md
# grant_burst_ctrl

Downstream stage of the 4-bit fixed-priority arbiter. Samples the arbiter's one-hot grant, locks ownership to the winning requester for a programmable burst of beats, and counts transferred beats. Releases ownership on burst completion or when the owner drops its request. Provides the rest of the design with a stable `owner` vector plus `done`/`aborted` pulses instead of the arbiter's cycle-by-cycle grant.

## Interface
- `N`, 4: number of requesters; width of `req`, `grant_in`, `owner`.
- `CNT_W`, 4: width of `burst_len` and `beats_left`; max burst is 2^CNT_W−1 beats.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  N  raw request lines, same vector the arbiter sees
- `grant_in`  in  N  arbiter output; expected one-hot or zero
- `burst_len`  in  CNT_W  beats per burst; sampled at lock; 0 is treated as 1
- `beat_valid`  in  1  owner presents a beat this cycle
- `owner`  out  N  locked one-hot owner; zero when not locked
- `busy`  out  1  high in XFER and RELEASE
- `beat_ready`  out  1  high in XFER only
- `beats_left`  out  CNT_W  remaining beats in the current burst
- `done`  out  1  one-cycle pulse after the final beat is accepted
- `aborted`  out  1  one-cycle pulse after the owner drops `req` mid-burst
- `grant_err`  out  1  one-cycle pulse when `grant_in` in IDLE has more than one bit set

## Operation
- All outputs are registered except `beat_ready`, which is decoded from state.
- States and transitions:
  - IDLE → XFER when `grant_in` is exactly one-hot. Loads `owner <= grant_in` and `beats_left <= (burst_len==0 ? 1 : burst_len)`.
  - IDLE stays in IDLE when `grant_in` is zero.
  - IDLE stays in IDLE when `grant_in` is multi-hot. Pulses `grant_err`; no lock.
  - XFER: a beat is accepted when `beat_valid && |(req & owner)`. Each accepted beat decrements `beats_left`.
  - XFER → RELEASE when a beat is accepted with `beats_left==1`. Pulses `done`; `beats_left` becomes 0.
  - XFER → RELEASE when `|(req & owner)==0`. Pulses `aborted`; `beats_left` holds its value.
  - RELEASE → IDLE unconditionally. `owner` clears on this edge.
- `grant_in` is ignored outside IDLE. Changes to the arbiter output mid-burst never move ownership.
- `beat_valid` outside XFER is ignored.
- Request drop and `beat_valid` in the same cycle: no beat is accepted and `aborted` fires. `done` and `aborted` are mutually exclusive.
- Beat counting uses CNT_W-bit unsigned arithmetic. `beats_left` never wraps because decrement happens only from values ≥1.

## Timing
- Reset values: state IDLE; `owner`=0, `busy`=0, `beat_ready`=0, `beats_left`=0, `done`=0, `aborted`=0, `grant_err`=0.
- Reset applied mid-burst clears everything immediately (asynchronously), with no `done` or `aborted` pulse.
- Grant sampled at edge E0 → `owner`, `busy`, and `beat_ready` are valid after E0.
- With `beat_valid` held high, an L-beat burst accepts beats at edges E1..EL.
- `done` is high during the cycle after EL; IDLE is entered at EL+1; the next grant is sampled at EL+2.
- Minimum ownership period is L+2 cycles per burst.
- Throughput is one beat per cycle while `beat_valid` and the owner's `req` are held.

## Structure
- Shared package `arb_pkg`: state encodings (IDLE=2'd0, XFER=2'd1, RELEASE=2'd2) and default `N`/`CNT_W` constants, reused by the arbiter and its testbench.
- Sub-module `onehot_check`: parameterised N-bit input; outputs `is_onehot` and `is_multi`. It classifies `grant_in` and is reusable for checking the arbiter output in benches.

## Test plan
- Reset then idle: `grant_in`=0000 for 5 cycles → `owner`=0000, `busy`=0, no pulses.
- Normal burst: `req`=0100, `grant_in`=0100, `burst_len`=3, `beat_valid`=1 → `owner`=0100, `beats_left` 3→2→1→0, `done` pulse once, `owner`=0000 two cycles after the last beat.
- Abort: lock `req`=0001 with `burst_len`=5; drop `req[0]` after 2 beats → `aborted` pulses, `beats_left`=3 held, no `done`.
- Lock stability: owner=0100 mid-burst while `grant_in` switches to 0001 (higher priority) → `owner` stays 0100 until RELEASE.
- Edge inputs: `burst_len`=0 → single-beat burst with `done`. `grant_in`=0101 in IDLE → `grant_err` pulse, stays IDLE.
- Async reset: assert `reset` mid-XFER between clock edges → all outputs 0 before the next edge; normal burst completes afterwards.
